vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA/SVGA raster timing generator; successor to the fixed 800x600@60 timing block.
//  Video mode comes from front-porch/sync/back-porch parameters.
//  Adds selectable sync polarity, pixel-advance enable, data-enable, start-of-frame/end-of-line
//  strobes and a frame counter.
//  Sits at the head of the draw pipeline; every downstream draw stage consumes its counters/strobes.
// PARAMETERS
//  H_ACTIVE  800  visible pixels per line
//  H_FP      40   horizontal front porch (pixels)
//  H_SYNC    128  hsync width (pixels)
//  H_BP      88   horizontal back porch (pixels)
//  V_ACTIVE  600  visible lines per frame
//  V_FP      1    vertical front porch (lines)
//  V_SYNC    4    vsync width (lines)
//  V_BP      23   vertical back porch (lines)
//  HS_POL    1    1 = hsync active-high, 0 = active-low
//  VS_POL    1    1 = vsync active-high, 0 = active-low
//  CNT_W     11   hcount/vcount width; must hold H_TOT-1 and V_TOT-1
//  FRAME_W   16   frame counter width
// PORTS
//  pclk       in   1        pixel clock; all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  en         in   1        advance enable; 0 = hold all outputs
//  hcount     out  CNT_W    pixel index in line, 0..H_TOT-1
//  vcount     out  CNT_W    line index in frame, 0..V_TOT-1
//  hsync      out  1        horizontal sync, polarity HS_POL
//  vsync      out  1        vertical sync, polarity VS_POL
//  hblnk      out  1        1 while hcount >= H_ACTIVE
//  vblnk      out  1        1 while vcount >= V_ACTIVE
//  de         out  1        ~hblnk & ~vblnk
//  sof        out  1        1-cycle strobe, counters just wrapped to (0,0)
//  eol        out  1        1 while hcount == H_TOT-1
//  frame_cnt  out  FRAME_W  completed-frame count
// BEHAVIOUR
//  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (defaults: 1056, 628).
//  - All outputs are registered; next-state logic is computed from the next counter values.
//    The flags are therefore consistent with hcount/vcount in the same cycle: zero skew, no extra latency.
//  - en=1: hcount increments each pclk and wraps H_TOT-1 -> 0.
//    vcount increments only on an hcount wrap and wraps V_TOT-1 -> 0.
//  - en=0: every output, strobes included, holds its value (a strobe active at freeze stays 1).
//  - hsync active  <=> H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; inactive level = ~HS_POL.
//  - vsync active  <=> V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, for the whole line (edges at hcount=0).
//    Inactive level = ~VS_POL.
//  - sof=1 only in the cycle entered via the (H_TOT-1, V_TOT-1) -> (0,0) transition.
//  - frame_cnt increments on that same edge; it wraps 2^FRAME_W-1 -> 0 silently.
//  - Reset (any cycle, mid-line or mid-frame):
//    - hcount=0, vcount=0, hblnk=0, vblnk=0, de=1;
//    - hsync=~HS_POL, vsync=~VS_POL;
//    - sof=0, eol=0, frame_cnt=0.
//    The first post-reset frame is full length and does not emit sof at its start.
//  - rst has priority over en.
//  - No state machine beyond the two counters; no illegal states reachable.
//  - Elaboration error if any porch/sync parameter < 1 or if CNT_W is too small.
// TESTING
//  1. Defaults, en=1, 2 full frames:
//     - hsync=1 for hcount 840..967 only;
//     - vsync=1 for vcount 601..604 only;
//     - hblnk for 800..1055, vblnk for 600..627.
//  2. Wrap: (1055,627) -> (0,0) with sof=1 for exactly 1 cycle and frame_cnt 0 -> 1.
//     eol=1 at every hcount=1055.
//  3. HS_POL=0, VS_POL=0: sync levels inverted vs test 1; reset drives hsync=vsync=1.
//  4. en toggled pseudo-randomly: hcount sequence has no gaps/duplicates in enabled cycles.
//     All outputs frozen while en=0, including a frozen sof=1.
//  5. rst asserted at (500,300) for 3 cycles:
//     - outputs at reset values;
//     - after release, hcount=1 on the first enabled edge;
//     - the next frame_cnt increment occurs 1056*628 enabled cycles after release.
//  6. Small mode (H: 8/2/2/2, V: 4/1/1/1, FRAME_W=2):
//     - H_TOT=14, V_TOT=7;
//     - frame_cnt wraps 3 -> 0 after 4 frames;
//     - de=1 only for hcount<8 and vcount<4.

Source files
------------

// File: rtl/vga_timing_if.sv
// Raster timing bundle: advance enable plus the counters and strobes fed to draw stages.
interface vga_timing_if #(
  parameter int CNT_W   = 11,
  parameter int FRAME_W = 16
);
  logic               en;
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;
  logic               de;
  logic               sof;
  logic               eol;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, eol, frame_cnt
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, de, sof, eol, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; every output is registered from the
// next counter values so flags line up with hcount/vcount in the same cycle.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 11,
  parameter int FRAME_W  = 16
) (
  input  logic          pclk,
  input  logic          rst,
  vga_timing_if.master  vif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be at least 1");
  end

  if ((longint'(H_TOT) > (longint'(1) << CNT_W)) ||
      (longint'(V_TOT) > (longint'(1) << CNT_W))) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too small for H_TOT-1 / V_TOT-1");
  end

  logic [CNT_W-1:0]   hcount_q;
  logic [CNT_W-1:0]   vcount_q;
  logic               hsync_q;
  logic               vsync_q;
  logic               hblnk_q;
  logic               vblnk_q;
  logic               de_q;
  logic               sof_q;
  logic               eol_q;
  logic [FRAME_W-1:0] frame_q;

  logic               h_wrap;
  logic               v_wrap;
  logic [CNT_W-1:0]   h_nxt;
  logic [CNT_W-1:0]   v_nxt;

  always_comb begin
    h_wrap = (hcount_q == H_LAST);
    v_wrap = (vcount_q == V_LAST);
    h_nxt  = h_wrap ? '0 : hcount_q + CNT_W'(1);
    v_nxt  = vcount_q;
    if (h_wrap) begin
      v_nxt = v_wrap ? '0 : vcount_q + CNT_W'(1);
    end
  end

  // Flags are derived from h_nxt/v_nxt so they register alongside the counters.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b1;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      frame_q  <= '0;
    end else if (vif.en) begin
      hcount_q <= h_nxt;
      vcount_q <= v_nxt;
      hsync_q  <= (h_nxt >= HS_START && h_nxt < HS_END) ? HS_POL : ~HS_POL;
      vsync_q  <= (v_nxt >= VS_START && v_nxt < VS_END) ? VS_POL : ~VS_POL;
      hblnk_q  <= (h_nxt >= H_ACT);
      vblnk_q  <= (v_nxt >= V_ACT);
      de_q     <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      sof_q    <= h_wrap && v_wrap;
      eol_q    <= (h_nxt == H_LAST);
      if (h_wrap && v_wrap) begin
        frame_q <= frame_q + FRAME_W'(1);
      end
    end
  end

  assign vif.hcount    = hcount_q;
  assign vif.vcount    = vcount_q;
  assign vif.hsync     = hsync_q;
  assign vif.vsync     = vsync_q;
  assign vif.hblnk     = hblnk_q;
  assign vif.vblnk     = vblnk_q;
  assign vif.de        = de_q;
  assign vif.sof       = sof_q;
  assign vif.eol       = eol_q;
  assign vif.frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four modes checked every cycle against a model that
// derives all outputs from the count of enabled edges since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        de;
    logic        sof;
    logic        eol;
    logic [31:0] fc;
  } vec_t;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst_def = 1'b1;
  logic rst_mid = 1'b1;
  logic rst_pol = 1'b1;
  logic rst_sml = 1'b1;

  vga_timing_if #(.CNT_W(11), .FRAME_W(16)) if_def ();
  vga_timing_if #(.CNT_W(6),  .FRAME_W(3))  if_mid ();
  vga_timing_if #(.CNT_W(6),  .FRAME_W(3))  if_pol ();
  vga_timing_if #(.CNT_W(4),  .FRAME_W(2))  if_sml ();

  vga_timing_gen u_def (.pclk(pclk), .rst(rst_def), .vif(if_def));

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .CNT_W(6), .FRAME_W(3)
  ) u_mid (.pclk(pclk), .rst(rst_mid), .vif(if_mid));

  vga_timing_gen #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(3), .V_BP(4),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .CNT_W(6), .FRAME_W(3)
  ) u_pol (.pclk(pclk), .rst(rst_pol), .vif(if_pol));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CNT_W(4), .FRAME_W(2)
  ) u_sml (.pclk(pclk), .rst(rst_sml), .vif(if_sml));

  int n_chk = 0;
  int n_err = 0;

  // Raster position is just k modulo the frame size; frames completed is k / frame size.
  function automatic vec_t model(longint k, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb,
                                 bit hp, bit vp, int fw);
    vec_t   e;
    longint ht  = ha + hf + hs + hb;
    longint vt  = va + vf + vs + vb;
    longint tot = ht * vt;
    longint p   = k % tot;
    longint h   = p % ht;
    longint v   = p / ht;
    e.h   = 32'(h);
    e.v   = 32'(v);
    e.hs  = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    e.vs  = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    e.hb  = (h >= ha);
    e.vb  = (v >= va);
    e.de  = (h < ha) && (v < va);
    e.sof = (k > 0) && (p == 0);
    e.eol = (h == ht - 1);
    e.fc  = 32'((k / tot) % (longint'(1) << fw));
    return e;
  endfunction

  function automatic vec_t dut_vec(logic [31:0] h, logic [31:0] v, logic hs, logic vs,
                                   logic hb, logic vb, logic de, logic sof, logic eol,
                                   logic [31:0] fc);
    return '{h, v, hs, vs, hb, vb, de, sof, eol, fc};
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_vec(string nm, vec_t g, vec_t e);
    n_chk++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b sof=%b eol=%b fc=%0d expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b de=%b sof=%b eol=%b fc=%0d",
               nm, $time, g.h, g.v, g.hs, g.vs, g.hb, g.vb, g.de, g.sof, g.eol, g.fc,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.de, e.sof, e.eol, e.fc);
    end
  endtask

  longint k_def = 0, k_mid = 0, k_pol = 0, k_sml = 0;
  bit vld_def = 0, vld_mid = 0, vld_pol = 0, vld_sml = 0;

  always @(posedge pclk) begin
    if (rst_def) begin k_def <= 0; vld_def <= 1'b1; end else if (if_def.en) k_def <= k_def + 1;
    if (rst_mid) begin k_mid <= 0; vld_mid <= 1'b1; end else if (if_mid.en) k_mid <= k_mid + 1;
    if (rst_pol) begin k_pol <= 0; vld_pol <= 1'b1; end else if (if_pol.en) k_pol <= k_pol + 1;
    if (rst_sml) begin k_sml <= 0; vld_sml <= 1'b1; end else if (if_sml.en) k_sml <= k_sml + 1;
  end

  always @(negedge pclk) begin
    if (vld_def)
      chk_vec("def", dut_vec(32'(if_def.hcount), 32'(if_def.vcount), if_def.hsync, if_def.vsync,
                             if_def.hblnk, if_def.vblnk, if_def.de, if_def.sof, if_def.eol,
                             32'(if_def.frame_cnt)),
              model(k_def, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16));
    if (vld_mid)
      chk_vec("mid", dut_vec(32'(if_mid.hcount), 32'(if_mid.vcount), if_mid.hsync, if_mid.vsync,
                             if_mid.hblnk, if_mid.vblnk, if_mid.de, if_mid.sof, if_mid.eol,
                             32'(if_mid.frame_cnt)),
              model(k_mid, 40, 4, 8, 6, 30, 2, 3, 4, 1'b1, 1'b1, 3));
    if (vld_pol)
      chk_vec("pol", dut_vec(32'(if_pol.hcount), 32'(if_pol.vcount), if_pol.hsync, if_pol.vsync,
                             if_pol.hblnk, if_pol.vblnk, if_pol.de, if_pol.sof, if_pol.eol,
                             32'(if_pol.frame_cnt)),
              model(k_pol, 40, 4, 8, 6, 30, 2, 3, 4, 1'b0, 1'b0, 3));
    if (vld_sml)
      chk_vec("sml", dut_vec(32'(if_sml.hcount), 32'(if_sml.vcount), if_sml.hsync, if_sml.vsync,
                             if_sml.hblnk, if_sml.vblnk, if_sml.de, if_sml.sof, if_sml.eol,
                             32'(if_sml.frame_cnt)),
              model(k_sml, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2));
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    vec_t m;
    int   rst_left;
    int   n_en;
    bit   found;
    bit   done;
    bit   seen_first;

    if_def.en = 1'b1;
    if_mid.en = 1'b1;
    if_pol.en = 1'b1;
    if_sml.en = 1'b1;

    // Hand-computed anchors for the model itself.
    m = model(1056 * 628 - 1, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_last_h", m.h, 1055);
    chk("pin_last_v", m.v, 627);
    chk("pin_last_eol", m.eol, 1);
    chk("pin_last_de", m.de, 0);
    m = model(1056 * 628, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_wrap_sof", m.sof, 1);
    chk("pin_wrap_fc", m.fc, 1);
    chk("pin_wrap_h", m.h, 0);
    m = model(839, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_hs_839", m.hs, 0);
    m = model(840, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_hs_840", m.hs, 1);
    m = model(967, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_hs_967", m.hs, 1);
    m = model(968, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_hs_968", m.hs, 0);
    m = model(1056 * 601, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_vs_601", m.vs, 1);
    m = model(1056 * 605, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16);
    chk("pin_vs_605", m.vs, 0);
    m = model(3 * 98, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2);
    chk("pin_sml_fc3", m.fc, 3);
    m = model(4 * 98, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2);
    chk("pin_sml_fc_wrap", m.fc, 0);
    chk("pin_sml_sof", m.sof, 1);
    m = model(7, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2);
    chk("pin_sml_de7", m.de, 1);
    m = model(8, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2);
    chk("pin_sml_de8", m.de, 0);
    m = model(4 * 14, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 2);
    chk("pin_sml_de_v4", m.de, 0);

    repeat (3) step();
    chk("rst_def_h", if_def.hcount, 0);
    chk("rst_def_de", if_def.de, 1);
    chk("rst_def_hs", if_def.hsync, 0);
    chk("rst_pol_hs", if_pol.hsync, 1);
    chk("rst_pol_vs", if_pol.vsync, 1);

    rst_def = 1'b0;
    rst_mid = 1'b0;
    rst_pol = 1'b0;
    rst_sml = 1'b0;
    step();
    chk("def_first_h", if_def.hcount, 1);

    rst_left = 0;
    for (int c = 0; c < 20000; c++) begin
      if_mid.en = ($urandom_range(0, 9) < 7);
      if_sml.en = ($urandom_range(0, 9) < 9);
      if (rst_left > 0) begin
        rst_mid = 1'b1;
        rst_left--;
      end else begin
        rst_mid = 1'b0;
        if ($urandom_range(0, 7999) == 0) rst_left = 3;
      end
      step();
    end

    rst_mid   = 1'b0;
    if_mid.en = 1'b1;
    if_sml.en = 1'b1;
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      step();
      if (if_mid.hcount == 20 && if_mid.vcount == 15) found = 1;
    end
    chk("seek_20_15", found, 1);

    rst_mid = 1'b1;
    repeat (3) begin
      if_mid.en = 1'($urandom_range(0, 1));
      step();
    end
    chk("rst_mid_h", if_mid.hcount, 0);
    chk("rst_mid_v", if_mid.vcount, 0);
    chk("rst_mid_de", if_mid.de, 1);
    chk("rst_mid_sof", if_mid.sof, 0);
    chk("rst_mid_fc", if_mid.frame_cnt, 0);

    rst_mid = 1'b0;
    n_en = 0;
    done = 0;
    seen_first = 0;
    for (int i = 0; i < 10000 && !done; i++) begin
      if_mid.en = ($urandom_range(0, 9) < 7);
      n_en += int'(if_mid.en);
      step();
      if (!seen_first && n_en == 1) begin
        seen_first = 1;
        chk("mid_first_edge_h", if_mid.hcount, 1);
      end
      if (if_mid.frame_cnt != 0) done = 1;
    end
    chk("frame_inc_seen", done, 1);
    chk("frame_inc_after", n_en, 58 * 39);

    if_mid.en = 1'b0;
    repeat (4) step();
    chk("frozen_sof", if_mid.sof, 1);
    chk("frozen_h", if_mid.hcount, 0);
    chk("frozen_fc", if_mid.frame_cnt, 1);
    if_mid.en = 1'b1;
    step();
    chk("thaw_sof", if_mid.sof, 0);
    chk("thaw_h", if_mid.hcount, 1);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
